top: RTL and testbench

TOP -- requirements
Module: top

---
 rtl/top.sv | 230 +++++++++++++++++++++++
 tb/tb_top.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/top.sv
// Reduced 8-bit SM83-style core: FETCH/DECODE/OP1/OP2/HALT sequencer over a synchronous byte ROM.
// Define TOP_JR_EN to execute JR e / JR cc,e; otherwise those opcodes are 2-byte NOPs.
module top #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [14:0] rom_addr,
  input  logic [7:0]  rom_data
);

  localparam int RA   = 0;
  localparam int RB   = 1;
  localparam int RC   = 2;
  localparam int RD   = 3;
  localparam int RE   = 4;
  localparam int RH   = 5;
  localparam int RL   = 6;
  localparam int RW   = 7;
  localparam int RZ   = 8;
  localparam int RSPH = 9;
  localparam int RSPL = 10;
  localparam int RPCH = 11;
  localparam int RPCL = 12;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_OP1, S_OP2, S_HALT} state_t;

  state_t           state_q, state_d;
  logic [12:0][7:0] rf_q, rf_d;
  logic [3:0]       flags_q, flags_d;
  logic [7:0]       ir_q, ir_d;
  logic [15:0]      pc, pc_d;
  logic [2:0]       dst, src;
  logic [7:0]       dst_v, src_v, inc_v;
  logic [11:0]      alu_res;

  // Opcode register code -> register file slot (code 6 is (HL), never used as a target)
  function automatic logic [3:0] ridx(input logic [2:0] code);
    case (code)
      3'd0:    ridx = 4'(RB);
      3'd1:    ridx = 4'(RC);
      3'd2:    ridx = 4'(RD);
      3'd3:    ridx = 4'(RE);
      3'd4:    ridx = 4'(RH);
      3'd5:    ridx = 4'(RL);
      default: ridx = 4'(RA);
    endcase
  endfunction

  // ALU op codes executed by this core; codes 1 and 3 decode as NOP
  function automatic logic alu_ok(input logic [2:0] op);
    alu_ok = (op != 3'd1) && (op != 3'd3);
  endfunction

  // Returns {flags, result}
  function automatic logic [11:0] alu(input logic [2:0] op, input logic [7:0] a,
                                      input logic [7:0] b, input logic [3:0] f);
    logic [8:0] s;
    logic [4:0] hs;
    logic [7:0] r;
    logic [3:0] nf;
    s  = {1'b0, a} + {1'b0, b};
    hs = {1'b0, a[3:0]} + {1'b0, b[3:0]};
    r  = a;
    nf = f;
    case (op)
      3'd0: begin
        r  = s[7:0];
        nf = {r == 8'h00, 1'b0, hs[4], s[8]};
      end
      3'd2, 3'd7: begin
        r  = a - b;
        nf = {r == 8'h00, 1'b1, a[3:0] < b[3:0], a < b};
      end
      3'd4: begin
        r  = a & b;
        nf = {r == 8'h00, 3'b010};
      end
      3'd5: begin
        r  = a ^ b;
        nf = {r == 8'h00, 3'b000};
      end
      3'd6: begin
        r  = a | b;
        nf = {r == 8'h00, 3'b000};
      end
      default: ;
    endcase
    alu = {nf, r};
  endfunction

  function automatic logic is_ld16(input logic [7:0] op);
    is_ld16 = (op & 8'hCF) == 8'h01;
  endfunction

  function automatic logic is_ldn(input logic [7:0] op);
    is_ldn = ((op & 8'hC7) == 8'h06) && (op[5:3] != 3'd6);
  endfunction

  function automatic logic is_alui(input logic [7:0] op);
    is_alui = ((op & 8'hC7) == 8'hC6) && alu_ok(op[5:3]);
  endfunction

  function automatic logic is_jr(input logic [7:0] op);
    is_jr = (op == 8'h18) || ((op & 8'hE7) == 8'h20);
  endfunction

  assign pc       = {rf_q[RPCH], rf_q[RPCL]};
  assign rom_addr = pc[14:0];
  assign dst      = rom_data[5:3];
  assign src      = rom_data[2:0];
  assign dst_v    = rf_q[ridx(dst)];
  assign src_v    = rf_q[ridx(src)];

`ifdef TOP_JR_EN
  logic jr_take;
  always_comb begin
    jr_take = 1'b1;
    if (ir_q[5]) begin
      case (ir_q[4:3])
        2'd0: jr_take = !flags_q[3];
        2'd1: jr_take =  flags_q[3];
        2'd2: jr_take = !flags_q[0];
        2'd3: jr_take =  flags_q[0];
      endcase
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    rf_d    = rf_q;
    flags_d = flags_q;
    ir_d    = ir_q;
    pc_d    = pc;
    inc_v   = 8'h00;
    alu_res = 12'h000;
    case (state_q)
      S_FETCH: begin
        pc_d    = pc + 16'd1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        ir_d    = rom_data;
        state_d = S_FETCH;
        if (rom_data == 8'h76) begin
          state_d = S_HALT;
        end else if (is_ld16(rom_data) || rom_data == 8'hC3 || is_ldn(rom_data) ||
                     is_alui(rom_data) || is_jr(rom_data)) begin
          pc_d    = pc + 16'd1;
          state_d = S_OP1;
        end else if (rom_data[7:6] == 2'b01) begin
          if (dst != 3'd6 && src != 3'd6) rf_d[ridx(dst)] = src_v;
        end else if ((rom_data & 8'hC7) == 8'h04) begin
          if (dst != 3'd6) begin
            inc_v           = dst_v + 8'd1;
            rf_d[ridx(dst)] = inc_v;
            flags_d         = {inc_v == 8'h00, 1'b0, dst_v[3:0] == 4'hF, flags_q[0]};
          end
        end else if ((rom_data & 8'hC7) == 8'h05) begin
          if (dst != 3'd6) begin
            inc_v           = dst_v - 8'd1;
            rf_d[ridx(dst)] = inc_v;
            flags_d         = {inc_v == 8'h00, 1'b1, dst_v[3:0] == 4'h0, flags_q[0]};
          end
        end else if (rom_data[7:6] == 2'b10) begin
          if (src != 3'd6 && alu_ok(dst)) begin
            alu_res = alu(dst, rf_q[RA], src_v, flags_q);
            flags_d = alu_res[11:8];
            if (dst != 3'd7) rf_d[RA] = alu_res[7:0];
          end
        end
      end
      S_OP1: begin
        rf_d[RZ] = rom_data;
        state_d  = S_FETCH;
        if (is_ld16(ir_q) || ir_q == 8'hC3) begin
          pc_d    = pc + 16'd1;
          state_d = S_OP2;
        end else if (is_ldn(ir_q)) begin
          rf_d[ridx(ir_q[5:3])] = rom_data;
        end else if (is_alui(ir_q)) begin
          alu_res = alu(ir_q[5:3], rf_q[RA], rom_data, flags_q);
          flags_d = alu_res[11:8];
          if (ir_q[5:3] != 3'd7) rf_d[RA] = alu_res[7:0];
`ifdef TOP_JR_EN
        end else if (is_jr(ir_q) && jr_take) begin
          // PC already points past the displacement byte
          pc_d = pc + {{8{rom_data[7]}}, rom_data};
`endif
        end
      end
      S_OP2: begin
        rf_d[RW] = rom_data;
        state_d  = S_FETCH;
        if (ir_q == 8'hC3) begin
          pc_d = {rom_data, rf_q[RZ]};
        end else begin
          case (ir_q[5:4])
            2'd0: begin rf_d[RB]   = rom_data; rf_d[RC]   = rf_q[RZ]; end
            2'd1: begin rf_d[RD]   = rom_data; rf_d[RE]   = rf_q[RZ]; end
            2'd2: begin rf_d[RH]   = rom_data; rf_d[RL]   = rf_q[RZ]; end
            2'd3: begin rf_d[RSPH] = rom_data; rf_d[RSPL] = rf_q[RZ]; end
          endcase
        end
      end
      S_HALT: ;
      default: state_d = S_FETCH;
    endcase
    rf_d[RPCH] = pc_d[15:8];
    rf_d[RPCL] = pc_d[7:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_FETCH;
      rf_q       <= '0;
      rf_q[RPCH] <= RESET_PC[15:8];
      rf_q[RPCL] <= RESET_PC[7:0];
      flags_q    <= 4'h0;
      ir_q       <= 8'h00;
    end else begin
      state_q <= state_d;
      rf_q    <= rf_d;
      flags_q <= flags_d;
      ir_q    <= ir_d;
    end
  end

endmodule

// File: tb/tb_top.sv
// Bench for top: instruction-level model drives a per-cycle rom_addr check and
// architectural-state checks at every instruction boundary, plus literal program results.
module tb_top;
  logic        clk = 1'b0;
  logic        rst;
  logic [14:0] rom_addr;
  logic [7:0]  rom_data;
  logic [7:0]  mem [0:32767];
  logic [7:0]  prog [$];

  int checks = 0;
  int errors = 0;
  bit active = 1'b0;

  // model state
  logic [7:0]  m_r [8];   // by opcode register code: B C D E H L - A
  logic [15:0] m_sp, m_pc, m_start;
  logic [3:0]  m_f;
  bit          m_halt;
  int          m_k, m_len;

  top dut (.clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_data(rom_data));

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= mem[rom_addr];

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [95:0] dut_arch();
    return {4'h0, dut.rf_q[0], dut.rf_q[1], dut.rf_q[2], dut.rf_q[3], dut.rf_q[4],
            dut.rf_q[5], dut.rf_q[6], dut.rf_q[9], dut.rf_q[10], dut.flags_q,
            dut.rf_q[11], dut.rf_q[12]};
  endfunction

  function automatic logic [95:0] m_arch();
    return {4'h0, m_r[7], m_r[0], m_r[1], m_r[2], m_r[3], m_r[4], m_r[5], m_sp, m_f, m_pc};
  endfunction

  // clocks taken by the instruction starting with this opcode
  function automatic int ilen(input logic [7:0] op);
    case (op)
      8'h01, 8'h11, 8'h21, 8'h31, 8'hC3: return 4;
      8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h3E,
      8'hC6, 8'hD6, 8'hE6, 8'hEE, 8'hF6, 8'hFE,
      8'h18, 8'h20, 8'h28, 8'h30, 8'h38: return 3;
      default: return 2;
    endcase
  endfunction

  task automatic m_alu(input int kind, input int b);
    int a, res;
    a = m_r[7];
    res = a;
    case (kind)
      0: begin
        res = (a + b) % 256;
        m_f = {res == 0, 1'b0, (a % 16 + b % 16) > 15, (a + b) > 255};
      end
      2, 7: begin
        res = (a - b + 256) % 256;
        m_f = {res == 0, 1'b1, (a % 16) < (b % 16), a < b};
      end
      4: begin res = a & b; m_f = {res == 0, 3'b010}; end
      5: begin res = a ^ b; m_f = {res == 0, 3'b000}; end
      6: begin res = a | b; m_f = {res == 0, 3'b000}; end
      default: return;
    endcase
    if (kind != 7) m_r[7] = 8'(res);
  endtask

  task automatic m_exec();
    logic [7:0] op, n1, n2;
    logic [15:0] nxt;
    int r, s, v, off;
    bit take;
    op  = mem[m_pc[14:0]];
    n1  = mem[15'(m_pc + 16'd1)];
    n2  = mem[15'(m_pc + 16'd2)];
    nxt = m_pc + 16'(m_len - 1);
    r   = (op / 8) % 8;
    s   = op % 8;
    if (op == 8'h76) m_halt = 1'b1;
    else if (op == 8'h01) begin m_r[0] = n2; m_r[1] = n1; end
    else if (op == 8'h11) begin m_r[2] = n2; m_r[3] = n1; end
    else if (op == 8'h21) begin m_r[4] = n2; m_r[5] = n1; end
    else if (op == 8'h31) m_sp = {n2, n1};
    else if (op == 8'hC3) nxt = {n2, n1};
    else if (op inside {8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h3E}) m_r[r] = n1;
    else if (op >= 8'h40 && op <= 8'h7F) begin
      if (r != 6 && s != 6) m_r[r] = m_r[s];
    end else if (op inside {8'h04, 8'h0C, 8'h14, 8'h1C, 8'h24, 8'h2C, 8'h3C}) begin
      v = (m_r[r] + 1) % 256;
      m_f = {v == 0, 1'b0, (m_r[r] % 16) == 15, m_f[0]};
      m_r[r] = 8'(v);
    end else if (op inside {8'h05, 8'h0D, 8'h15, 8'h1D, 8'h25, 8'h2D, 8'h3D}) begin
      v = (m_r[r] + 255) % 256;
      m_f = {v == 0, 1'b1, (m_r[r] % 16) == 0, m_f[0]};
      m_r[r] = 8'(v);
    end else if (op >= 8'h80 && op <= 8'hBF) begin
      if (s != 6) m_alu(r, m_r[s]);
    end else if (op inside {8'hC6, 8'hD6, 8'hE6, 8'hEE, 8'hF6, 8'hFE}) begin
      m_alu(r, n1);
    end else if (op inside {8'h18, 8'h20, 8'h28, 8'h30, 8'h38}) begin
      take = (op == 8'h18) || (op == 8'h20 && !m_f[3]) || (op == 8'h28 && m_f[3]) ||
             (op == 8'h30 && !m_f[0]) || (op == 8'h38 && m_f[0]);
`ifdef TOP_JR_EN
      off = (n1 > 127) ? int'(n1) - 256 : int'(n1);
      if (take) nxt = 16'((int'(nxt) + off + 65536) % 65536);
`else
      off = 0;
      if (take) nxt = nxt + 16'(off);
`endif
    end
    m_pc = nxt;
  endtask

  always @(negedge clk) begin
    if (active) begin
      if (m_halt) begin
        chk("halt_arch", dut_arch(), m_arch());
        chk("halt_addr", 96'(rom_addr), 96'(m_pc[14:0]));
      end else begin
        if (m_k == 0) begin
          chk("arch", dut_arch(), m_arch());
          m_start = m_pc;
          m_len   = ilen(mem[m_pc[14:0]]);
        end
        chk("rom_addr", 96'(rom_addr), 96'(15'(m_start + 16'(m_k))));
        m_k++;
        if (m_k == m_len) begin
          m_exec();
          m_k = 0;
        end
      end
    end
  end

  task automatic prep();
    active = 1'b0;
    rst    = 1'b0;
    for (int i = 0; i < 32768; i++) mem[i] = 8'h00;
    foreach (prog[i]) mem[i] = prog[i];
  endtask

  task automatic go();
    for (int i = 0; i < 8; i++) m_r[i] = 8'h00;
    m_sp = 16'h0; m_pc = 16'h0; m_f = 4'h0; m_halt = 1'b0;
    m_k = 0; m_len = 0; m_start = 16'h0;
    @(posedge clk);
    #1 rst = 1'b1;
    active = 1'b1;
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    #2;
    chk("reset_addr", 96'(rom_addr), 96'h0);
    chk("reset_arch", dut_arch(), 96'h0);

    // LD A,5; INC A; HALT
    prog = '{8'h3E, 8'h05, 8'h3C, 8'h76};
    prep(); go(); edges(12);
    chk("t1_A", 96'(dut.rf_q[0]), 96'h06);
    chk("t1_flags", 96'(dut.flags_q), 96'h0);
    chk("t1_addr", 96'(rom_addr), 96'h0004);

    // LD SP,FFFE then NOPs
    prog = '{8'h31, 8'hFE, 8'hFF, 8'h00};
    prep(); go(); edges(4);
    chk("t2_SP", 96'({dut.rf_q[9], dut.rf_q[10]}), 96'hFFFE);
    chk("t2_PC", 96'({dut.rf_q[11], dut.rf_q[12]}), 96'h0003);
    edges(6);

    // ADD imm half carry, CP imm equal
    prog = '{8'h3E, 8'h0F, 8'hC6, 8'h01, 8'hFE, 8'h10, 8'h76};
    prep(); go(); edges(6);
    chk("t3_A_add", 96'(dut.rf_q[0]), 96'h10);
    chk("t3_f_add", 96'(dut.flags_q), 96'b0010);
    edges(3);
    chk("t3_A_cp", 96'(dut.rf_q[0]), 96'h10);
    chk("t3_f_cp", 96'(dut.flags_q), 96'b1100);
    edges(4);

    // JP 0150 with HALT there
    prog = '{8'hC3, 8'h50, 8'h01};
    prep(); mem[16'h0150] = 8'h76; go(); edges(4);
    chk("t4_jp_addr", 96'(rom_addr), 96'h0150);
    edges(6);
    chk("t4_PC", 96'({dut.rf_q[11], dut.rf_q[12]}), 96'h0151);
    chk("t4_addr", 96'(rom_addr), 96'h0151);

    // LD B,3; loop: DEC B; JR NZ,loop; HALT
    prog = '{8'h06, 8'h03, 8'h05, 8'h20, 8'hFD, 8'h76};
    prep(); go(); edges(26);
`ifdef TOP_JR_EN
    chk("t5_B", 96'(dut.rf_q[1]), 96'h00);
    chk("t5_flags", 96'(dut.flags_q), 96'b1100);
`else
    chk("t5_B", 96'(dut.rf_q[1]), 96'h02);
    chk("t5_flags", 96'(dut.flags_q), 96'b0100);
`endif
    chk("t5_PC", 96'({dut.rf_q[11], dut.rf_q[12]}), 96'h0006);

    // reset in OP1 of LD SP,nn, then restart
    prog = '{8'h31, 8'hFE, 8'hFF, 8'h00};
    prep(); go(); edges(2);
    active = 1'b0;
    rst = 1'b0;
    #1;
    chk("t6_addr", 96'(rom_addr), 96'h0);
    chk("t6_SP", 96'({dut.rf_q[9], dut.rf_q[10]}), 96'h0);
    go(); edges(6);
    chk("t6_SP_rerun", 96'({dut.rf_q[9], dut.rf_q[10]}), 96'hFFFE);

    // ALU mix, LD r,r', INC/DEC, (HL) forms and unlisted opcodes as NOPs
    prog = '{8'h3E, 8'h3C, 8'h06, 8'h0F, 8'h0E, 8'hF0, 8'h80, 8'h91, 8'hA0, 8'hA9,
             8'hB0, 8'h57, 8'h1C, 8'h15, 8'h46, 8'h34, 8'h86, 8'h88, 8'hD3, 8'hB8,
             8'hEE, 8'hFF, 8'hD6, 8'h01, 8'hE6, 8'h0F, 8'hF6, 8'hF0, 8'h3D, 8'h76};
    prep(); go(); edges(60);
    chk("t7_A", 96'(dut.rf_q[0]), 96'hFE);
    chk("t7_flags", 96'(dut.flags_q), 96'b0100);
    chk("t7_BCDE", 96'({dut.rf_q[1], dut.rf_q[2], dut.rf_q[3], dut.rf_q[4]}), 96'h0FF0FE01);
    chk("t7_PC", 96'({dut.rf_q[11], dut.rf_q[12]}), 96'h001E);

    // 16-bit loads, ADD carry out and wrap to zero
    prog = '{8'h01, 8'h34, 8'h12, 8'h11, 8'h78, 8'h56, 8'h21, 8'hBC, 8'h9A,
             8'h3E, 8'hF0, 8'hC6, 8'h20, 8'hC6, 8'hF0, 8'h76};
    prep(); go(); edges(18);
    chk("t8_A_c", 96'(dut.rf_q[0]), 96'h10);
    chk("t8_f_c", 96'(dut.flags_q), 96'b0001);
    edges(8);
    chk("t8_regs", 96'({dut.rf_q[1], dut.rf_q[2], dut.rf_q[3], dut.rf_q[4], dut.rf_q[5],
                        dut.rf_q[6]}), 96'h123456789ABC);
    chk("t8_A", 96'(dut.rf_q[0]), 96'h00);
    chk("t8_flags", 96'(dut.flags_q), 96'b1001);
    chk("t8_PC", 96'({dut.rf_q[11], dut.rf_q[12]}), 96'h0010);

    active = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
